// File: rtl/nes_loader_pkg.sv
// Shared types for the ROM loader write path: address/data widths and the
// packed write record carried from the loader to the SDRAM write port.
package nes_loader_pkg;

  localparam int LDR_ADDR_W = 22;
  localparam int LDR_DATA_W = 8;

  typedef struct packed {
    logic [LDR_ADDR_W-1:0] addr;
    logic [LDR_DATA_W-1:0] data;
  } ldr_wr_t;

  // Occupancy counter width: one bit wider than the pointers so full != empty.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/loader_fifo_ram.sv
// Loader write FIFO storage: DEPTH x entry register array with a synchronous
// write port and an asynchronous read at the read pointer (head is always visible).
import nes_loader_pkg::*;

module loader_fifo_ram #(
  parameter int  DEPTH   = 8,
  parameter type entry_t = ldr_wr_t,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  entry_t           wr_entry,
  input  logic [PTR_W-1:0] rd_ptr,
  output entry_t           rd_entry
);

  // Storage is deliberately left unreset; only the pointers define validity.
  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/loader_write_fifo.sv
// Buffers ROM-loader byte writes and drains one per SDRAM slot, back-pressuring
// the download via wait_out. Optional running checksum: LOADER_WFIFO_CHKSUM_EN.
import nes_loader_pkg::*;

module loader_write_fifo #(
  parameter int  DEPTH     = 8,
  parameter int  ADDR_W    = LDR_ADDR_W,
  parameter int  DATA_W    = LDR_DATA_W,
  parameter int  AFULL_LVL = 6,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = occ_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              slot,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              wait_out,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
`ifdef LOADER_WFIFO_CHKSUM_EN
  ,
  output logic [15:0]       chksum
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              mem_write_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_data_reg;
  logic              overflow_reg;

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;
  wr_t  wr_entry;
  wr_t  head;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  // A pop frees the head this cycle, so a full FIFO can still take a push.
  assign pop  = slot & ~empty & ~flush;
  assign push = in_valid & (~full | pop) & ~flush;
  assign drop = in_valid & full & ~pop & ~flush;

  assign wr_entry = {in_addr, in_data};

  loader_fifo_ram #(
    .DEPTH   (DEPTH),
    .entry_t (wr_t)
  ) u_ram (
    .clk      (clk),
    .wr_en    (push),
    .wr_ptr   (wr_ptr_reg),
    .wr_entry (wr_entry),
    .rd_ptr   (rd_ptr_reg),
    .rd_entry (head)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_data_reg  <= '0;
      overflow_reg  <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      mem_write_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (drop) begin
        overflow_reg <= 1'b1;
      end
      // Outputs only move on a slot strobe, so each write spans a full slot.
      if (slot) begin
        mem_write_reg <= pop;
        if (pop) begin
          mem_addr_reg <= head.addr;
          mem_data_reg <= head.data;
        end
      end
    end
  end

`ifdef LOADER_WFIFO_CHKSUM_EN
  logic [15:0] chksum_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chksum_reg <= '0;
    end else if (flush) begin
      chksum_reg <= '0;
    end else if (pop) begin
      chksum_reg <= chksum_reg + 16'(head.data);
    end
  end

  assign chksum = chksum_reg;
`endif

  assign mem_write = mem_write_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_data  = mem_data_reg;
  assign overflow  = overflow_reg;
  assign count     = count_reg;
  assign wait_out  = (count_reg >= CNT_W'(AFULL_LVL));

endmodule

// File: tb/tb_loader_write_fifo.sv
// Self-checking bench for loader_write_fifo: vector table, hand sequences for
// flush / async reset / checksum, and randomized traffic against a queue model.
module tb_loader_write_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 22;
  localparam int DW    = 8;
  localparam int AFULL = 6;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          slot;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          wait_out;
  logic [CW-1:0] count;
  logic          overflow;
`ifdef LOADER_WFIFO_CHKSUM_EN
  logic [15:0]   chksum;
`endif

  loader_write_fifo #(
    .DEPTH     (DEPTH),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .AFULL_LVL (AFULL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .slot      (slot),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .wait_out  (wait_out),
    .count     (count),
    .overflow  (overflow)
`ifdef LOADER_WFIFO_CHKSUM_EN
    ,
    .chksum    (chksum)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue plus the presented-write registers.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic          m_mw;
  logic [AW-1:0] m_ma;
  logic [DW-1:0] m_md;
  logic          m_ovf;
  logic [15:0]   m_cs;

  task automatic model_reset();
    q.delete();
    m_mw = 0; m_ma = '0; m_md = '0; m_ovf = 0; m_cs = '0;
  endtask

  task automatic model_step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic s, input logic f);
    ent_t e;
    bit   was_full;
    bit   do_pop;
    if (f) begin
      q.delete();
      m_ovf = 0; m_mw = 0; m_cs = '0;
      return;
    end
    was_full = (q.size() == DEPTH);
    do_pop   = s && (q.size() > 0);
    if (s) begin
      m_mw = do_pop;
      if (do_pop) begin
        e    = q.pop_front();
        m_ma = e.a;
        m_md = e.d;
        m_cs = m_cs + 16'(e.d);
      end
    end
    if (v) begin
      if (!was_full || do_pop) begin
        e.a = a; e.d = d;
        q.push_back(e);
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".mem_write"}, 32'(mem_write), 32'(m_mw));
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(m_ma));
    chk({tag, ".mem_data"}, 32'(mem_data), 32'(m_md));
    chk({tag, ".wait_out"}, 32'(wait_out), 32'(q.size() >= AFULL));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
`ifdef LOADER_WFIFO_CHKSUM_EN
    chk({tag, ".chksum"}, 32'(chksum), 32'(m_cs));
`endif
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic s, input logic f);
    in_valid = v; in_addr = a; in_data = d; slot = s; flush = f;
    @(posedge clk);
    #1;
    model_step(v, a, d, s, f);
    in_valid = 0; slot = 0; flush = 0;
  endtask

  task automatic chk_basic(input string tag, input logic mw, input int cnt,
                           input logic wt, input logic ovf);
    chk({tag, ".mem_write"}, 32'(mem_write), 32'(mw));
    chk({tag, ".count"}, 32'(count), 32'(cnt));
    chk({tag, ".wait_out"}, 32'(wait_out), 32'(wt));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
  endtask

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          s;
    logic          f;
    logic          e_mw;
    logic [AW-1:0] e_ma;
    logic [DW-1:0] e_md;
    int            e_cnt;
    logic          e_wait;
    logic          e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input int a, input int d, input logic s, input logic f,
                     input logic mw, input int ma, input int md, input int cnt,
                     input logic ovf);
    vec_t r;
    r.v = v; r.a = AW'(a); r.d = DW'(d); r.s = s; r.f = f;
    r.e_mw = mw; r.e_ma = AW'(ma); r.e_md = DW'(md); r.e_cnt = cnt;
    r.e_wait = (cnt >= AFULL); r.e_ovf = ovf;
    tbl.push_back(r);
  endtask

  initial begin
    reset_n = 0; flush = 0; in_valid = 0; in_addr = '0; in_data = '0; slot = 0;
    model_reset();

    // Single write presented for exactly one slot period.
    add(1, 'h10, 'hA5, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 1, 'h10, 'hA5, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 1, 'h10, 'hA5, 0, 0);
    add(0, 0, 0, 1, 0, 0, 'h10, 'hA5, 0, 0);
    // Fill to full, then overflow.
    for (int k = 0; k < 8; k++) add(1, k, 'h10 + k, 0, 0, 0, 'h10, 'hA5, k + 1, 0);
    add(1, 8, 'h18, 0, 0, 0, 'h10, 'hA5, 8, 1);
    // Flush wins over a same-cycle push.
    add(1, 'h3F, 'h55, 0, 1, 0, 'h10, 'hA5, 0, 0);
    for (int k = 0; k < 8; k++) add(1, k, 'h10 + k, 0, 0, 0, 'h10, 'hA5, k + 1, 0);
    // Full with simultaneous push and pop: accepted, no overflow.
    add(1, 'h20, 'h99, 1, 0, 1, 0, 'h10, 8, 0);
    for (int j = 0; j < 8; j++)
      add(0, 0, 0, 1, 0, 1, (j < 7) ? j + 1 : 'h20, (j < 7) ? 'h11 + j : 'h99, 7 - j, 0);
    add(0, 0, 0, 1, 0, 0, 'h20, 'h99, 0, 0);
    // Push coinciding with slot on empty waits for the next slot.
    add(1, 'h30, 'h31, 1, 0, 0, 'h20, 'h99, 1, 0);
    add(0, 0, 0, 1, 0, 1, 'h30, 'h31, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk_basic("reset_low", 0, 0, 0, 0);
    chk("reset_low.mem_addr", 32'(mem_addr), 0);
    chk("reset_low.mem_data", 32'(mem_data), 0);
    reset_n = 1;

    for (int c = 0; c < 16; c++) begin
      drive(0, 0, 0, (c % 4) == 3, 0);
      chk_basic($sformatf("idle%0d", c), 0, 0, 0, 0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].f);
      chk_basic($sformatf("vec%0d", i), tbl[i].e_mw, tbl[i].e_cnt, tbl[i].e_wait, tbl[i].e_ovf);
      chk($sformatf("vec%0d.mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_ma));
      chk($sformatf("vec%0d.mem_data", i), 32'(mem_data), 32'(tbl[i].e_md));
    end

    // Flush with 5 entries, overflow set and a write in flight.
    for (int k = 0; k < 9; k++) drive(1, 'h40 + k, k, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 1, 0);
    chk_basic("preflush", 1, 5, 0, 1);
    chk("preflush.mem_addr", 32'(mem_addr), 'h42);
    drive(1, 'h77, 'h77, 0, 1);
    chk_basic("flush", 0, 0, 0, 0);
    for (int c = 0; c < 8; c++) begin
      drive(0, 0, 0, (c % 4) == 3, 0);
      chk_basic($sformatf("postflush%0d", c), 0, 0, 0, 0);
    end

    // Wrapping checksum, then asynchronous reset mid-slot.
    drive(1, 'h100, 'hFF, 0, 0);
    drive(1, 'h101, 'hFF, 0, 0);
    drive(1, 'h102, 'h02, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 1, 0);
    chk_basic("cs_drain", 1, 0, 0, 0);
    chk("cs_drain.mem_data", 32'(mem_data), 'h02);
`ifdef LOADER_WFIFO_CHKSUM_EN
    chk("cs_drain.chksum", 32'(chksum), 'h0200);
`endif
    drive(1, 'h103, 'h44, 0, 0);
    #2;
    reset_n = 0;
    #1;
    chk_basic("async_reset", 0, 0, 0, 0);
`ifdef LOADER_WFIFO_CHKSUM_EN
    chk("async_reset.chksum", 32'(chksum), 0);
`endif
    @(posedge clk);
    #1;
    reset_n = 1;
    model_reset();

    // Randomized traffic: bursty loader writes, nominal 1-in-4 slots, rare flush.
    for (int c = 0; c < 3000; c++) begin
      int  pct;
      logic v, f;
      pct = ((c / 200) % 2 == 0) ? 70 : 20;
      v   = ($urandom_range(99) < pct);
      f   = ($urandom_range(299) == 0);
      drive(v, AW'($urandom), DW'($urandom), (c % 4) == 3, f);
      check_model($sformatf("rnd%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
